alu_pipeline_param: RTL

- Parametrised successor of the 3-stage toy core: fetch/decode, execute, write-back.
- Adds the following over the fixed 8x32 version:
  - parametrised data width, register count and PC width
  - active-low asynchronous reset
  - fetch-valid handshake
  - full operand forwarding
  - SUB opcodes
  - early-terminating shift-add multiplier
  - illegal-opcode flag
- Sits between the instruction memory model and the contract-synthesis harness, which observes the retire_o, retire_instr_o and regfile_o ports.

---
 rtl/alu_pipeline_param.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_pipeline_param.sv
// Three-stage parametrised toy core: fetch/decode, execute, write-back, with full
// operand forwarding and an early-terminating shift-add multiplier in EX.
module alu_pipeline_param #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 8,
    parameter int PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(16'h10)
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic [31:0]              instr_i,
    input  logic                     instr_valid_i,
    output logic [PC_WIDTH-1:0]      instr_addr_o,
    output logic                     fetch_o,
    output logic                     retire_o,
    output logic [31:0]              retire_instr_o,
    output logic                     illegal_o,
    output logic                     busy_o,
    output logic [NUM_REGS*XLEN-1:0] regfile_o
);

    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic in_range(input logic [7:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [PC_WIDTH-1:0] pc;

    logic                ex_valid;
    logic [31:0]         ex_instr;
    logic [XLEN-1:0]     ex_a, ex_b, ex_acc;

    logic                wb_valid, wb_write, wb_illegal;
    logic [31:0]         wb_instr;
    logic [7:0]          wb_rd;
    logic [XLEN-1:0]     wb_result;

    logic [7:0]          ex_op, ex_rd;
    logic                ex_is_mul, ex_writes, ex_finish, stall;
    logic [XLEN-1:0]     mul_acc_next, mul_m_next, ex_result;

    logic [7:0]          d_op, d_rs1, d_rs2;
    logic                d_reg_op;
    logic [XLEN-1:0]     rs1_val, rs2_val, d_op2;

    // While a multiply iterates, ex_a/ex_b double as the shifted multiplicand and
    // the remaining multiplier bits; the step below is the one taken this cycle.
    always_comb begin
        ex_op        = ex_instr[31:24];
        ex_rd        = ex_instr[23:16];
        ex_is_mul    = (ex_op == 8'd3) || (ex_op == 8'd4);
        ex_writes    = (ex_op >= 8'd1) && (ex_op <= 8'd6) && in_range(ex_rd);
        mul_acc_next = ex_acc + (ex_b[0] ? ex_a : '0);
        mul_m_next   = ex_b >> 1;
        ex_finish    = !ex_is_mul || (mul_m_next == '0);
        stall        = ex_valid && !ex_finish;
        case (ex_op)
            8'd1, 8'd2: ex_result = ex_a + ex_b;
            8'd3, 8'd4: ex_result = mul_acc_next;
            8'd5, 8'd6: ex_result = ex_a - ex_b;
            default:    ex_result = '0;
        endcase
    end

    // Operand read with forwarding: a finishing EX result beats the retiring WB
    // value, which beats the register file.
    always_comb begin
        d_op     = instr_i[31:24];
        d_rs1    = instr_i[15:8];
        d_rs2    = instr_i[7:0];
        d_reg_op = (d_op == 8'd1) || (d_op == 8'd3) || (d_op == 8'd5);
        rs1_val  = '0;
        rs2_val  = '0;
        if (in_range(d_rs1))
            rs1_val = regs[d_rs1[IDXW-1:0]];
        if (in_range(d_rs2))
            rs2_val = regs[d_rs2[IDXW-1:0]];
        if (wb_valid && wb_write && (wb_rd == d_rs1))
            rs1_val = wb_result;
        if (wb_valid && wb_write && (wb_rd == d_rs2))
            rs2_val = wb_result;
        if (ex_valid && ex_finish && ex_writes && (ex_rd == d_rs1))
            rs1_val = ex_result;
        if (ex_valid && ex_finish && ex_writes && (ex_rd == d_rs2))
            rs2_val = ex_result;
        d_op2 = d_reg_op ? rs2_val : XLEN'(d_rs2);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc       <= RESET_PC;
            ex_valid <= 1'b0;
            ex_instr <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_acc   <= '0;
        end else if (stall) begin
            ex_a   <= ex_a << 1;
            ex_b   <= mul_m_next;
            ex_acc <= mul_acc_next;
        end else if (instr_valid_i) begin
            pc       <= pc + PC_WIDTH'(4);
            ex_valid <= 1'b1;
            ex_instr <= instr_i;
            ex_a     <= rs1_val;
            ex_b     <= d_op2;
            ex_acc   <= '0;
        end else begin
            ex_valid <= 1'b0;
            ex_instr <= '0;
        end
    end

    // A stalled EX sends a bubble into WB.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wb_valid   <= 1'b0;
            wb_write   <= 1'b0;
            wb_illegal <= 1'b0;
            wb_instr   <= '0;
            wb_rd      <= '0;
            wb_result  <= '0;
        end else begin
            wb_valid   <= ex_valid && !stall;
            wb_write   <= ex_valid && !stall && ex_writes;
            wb_illegal <= ex_valid && (ex_op > 8'd6);
            wb_instr   <= ex_instr;
            wb_rd      <= ex_rd;
            wb_result  <= ex_result;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_REGS; k++)
                regs[k] <= '0;
        end else if (wb_valid && wb_write) begin
            regs[wb_rd[IDXW-1:0]] <= wb_result;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regfile_o[k*XLEN +: XLEN] = regs[k];
    end

    assign instr_addr_o   = pc;
    assign fetch_o        = !stall;
    assign busy_o         = stall;
    assign retire_o       = wb_valid;
    assign retire_instr_o = wb_valid ? wb_instr : 32'h0;
    assign illegal_o      = wb_valid && wb_illegal;

endmodule
